// File: rtl/video_anim_ctrl_if.sv
// Host configuration write port for video_anim_ctrl.
//   cfg_valid : write request (host -> controller)
//   cfg_ready : one-entry write buffer empty (controller -> host)
//   cfg_addr  : 0 = speed A, 1 = speed B, 2 = ctrl {step, run}, 3 = zero angles
//   cfg_data  : write data, ANG_W bits
interface video_anim_ctrl_if #(
  parameter int unsigned ANG_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_addr;
  logic [ANG_W-1:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/video_anim_ctrl.sv
// Frame-synchronous animation controller. Tracks frame events (rising vblank)
// and owns the rotation angles A/B. Host writes are staged through a one-entry
// buffer into shadow registers and only affect the angles at frame events.
// Ports:
//   clk_i, rst_ni     pixel clock, synchronous active-low reset
//   cen_i             clock enable for all state
//   vh_blank_i        [1] vblank, [0] hblank (hblank not needed here)
//   cfg               configuration write port (slave side)
//   angle_a_o/_b_o    committed angles
//   frame_cnt_o       frames seen since reset
//   frame_tick_o      high for the cen cycle after a frame event
//   state_o           0 = STOP, 1 = RUN, 2 = STEP
module video_anim_ctrl #(
  parameter int unsigned ANG_W     = 8,
  parameter int unsigned FRM_W     = 16,
  parameter int unsigned SPD_A_RST = 2,
  parameter int unsigned SPD_B_RST = 1,
  parameter bit          RUN_RST   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cen_i,
  input  logic [1:0]        vh_blank_i,
  video_anim_ctrl_if.slave  cfg,
  output logic [ANG_W-1:0]  angle_a_o,
  output logic [ANG_W-1:0]  angle_b_o,
  output logic [FRM_W-1:0]  frame_cnt_o,
  output logic              frame_tick_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {StStop = 2'd0, StRun = 2'd1, StStep = 2'd2} state_e;

  state_e           r_state;
  logic [ANG_W-1:0] r_angle_a, r_angle_b;
  logic [FRM_W-1:0] r_frame_cnt;
  logic             r_tick;
  logic             r_vblank_prev;
  logic             r_buf_full;
  logic [1:0]       r_buf_addr;
  logic [ANG_W-1:0] r_buf_data;
  logic [ANG_W-1:0] r_spd_a, r_spd_b;
  logic             r_run_sh, r_step_sh, r_zero_sh;

  logic w_fe;
  logic w_accept;
  logic w_unused_hblank;

  assign w_unused_hblank = vh_blank_i[0];

  assign w_fe      = cen_i & vh_blank_i[1] & ~r_vblank_prev;
  assign w_accept  = cfg.cfg_valid & ~r_buf_full & cen_i;
  assign cfg.cfg_ready = ~r_buf_full;

  assign angle_a_o    = r_angle_a;
  assign angle_b_o    = r_angle_b;
  assign frame_cnt_o  = r_frame_cnt;
  assign frame_tick_o = r_tick;
  assign state_o      = r_state;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= StStop;
      r_angle_a     <= '0;
      r_angle_b     <= '0;
      r_frame_cnt   <= '0;
      r_tick        <= 1'b0;
      // Starts high so a vblank already asserted at release is not a frame event.
      r_vblank_prev <= 1'b1;
      r_buf_full    <= 1'b0;
      r_buf_addr    <= '0;
      r_buf_data    <= '0;
      r_spd_a       <= ANG_W'(SPD_A_RST);
      r_spd_b       <= ANG_W'(SPD_B_RST);
      r_run_sh      <= RUN_RST;
      r_step_sh     <= 1'b0;
      r_zero_sh     <= 1'b0;
    end else if (cen_i) begin
      r_vblank_prev <= vh_blank_i[1];
      r_tick        <= w_fe;

      // Frame event: everything below sees pre-event state and shadows.
      if (w_fe) begin
        r_frame_cnt <= r_frame_cnt + FRM_W'(1);
        if (r_zero_sh) begin
          r_angle_a <= '0;
          r_angle_b <= '0;
          r_zero_sh <= 1'b0;
        end else if (r_state != StStop) begin
          r_angle_a <= r_angle_a + r_spd_a;
          r_angle_b <= r_angle_b + r_spd_b;
        end
        unique case (r_state)
          StStop: begin
            if (r_run_sh) begin
              r_state <= StRun;
            end else if (r_step_sh) begin
              r_state   <= StStep;
              r_step_sh <= 1'b0;
            end
          end
          StRun:   if (!r_run_sh) r_state <= StStop;
          StStep:  r_state <= StStop;
          default: r_state <= StStop;
        endcase
      end

      // Drain is held off during a frame event, so it never races the
      // event's own shadow updates (step/zero clears).
      if (r_buf_full && !w_fe) begin
        r_buf_full <= 1'b0;
        unique case (r_buf_addr)
          2'd0: r_spd_a <= r_buf_data;
          2'd1: r_spd_b <= r_buf_data;
          2'd2: begin
            r_run_sh  <= r_buf_data[0];
            r_step_sh <= r_buf_data[1];
          end
          default: r_zero_sh <= 1'b1;
        endcase
      end else if (w_accept) begin
        r_buf_full <= 1'b1;
        r_buf_addr <= cfg.cfg_addr;
        r_buf_data <= cfg.cfg_data;
      end
    end
  end

endmodule

// File: tb/tb_video_anim_ctrl.sv
// Directed bench for video_anim_ctrl: frame events, speed/ctrl/zero writes,
// back-to-back writes across a frame event, clock-enable gating and reset.
module tb_video_anim_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic [1:0]  vh = 2'b00;
  logic [7:0]  ang_a, ang_b;
  logic [15:0] frm;
  logic        tick;
  logic [1:0]  st;

  int n_tests = 0;
  int n_fail  = 0;

  video_anim_ctrl_if #(.ANG_W(8)) cfg_if ();

  video_anim_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cen_i        (cen),
    .vh_blank_i   (vh),
    .cfg          (cfg_if),
    .angle_a_o    (ang_a),
    .angle_b_o    (ang_b),
    .frame_cnt_o  (frm),
    .frame_tick_o (tick),
    .state_o      (st)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One vblank rising edge; returns just after the frame-event edge.
  task automatic fe();
    vh = 2'b10;
    cyc();
    vh = 2'b00;
  endtask

  // Check the results of a frame event, then that the tick lasts one cycle.
  task automatic chk_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] f, input logic [1:0] s);
    chk({tag, "_tick"}, {31'd0, tick}, 32'd1);
    chk({tag, "_a"}, {24'd0, ang_a}, {24'd0, a});
    chk({tag, "_b"}, {24'd0, ang_b}, {24'd0, b});
    chk({tag, "_frm"}, {16'd0, frm}, {16'd0, f});
    chk({tag, "_st"}, {30'd0, st}, {30'd0, s});
    cyc();
    chk({tag, "_tick_clr"}, {31'd0, tick}, 32'd0);
  endtask

  // Single write with a drain cycle; checks the buffer fills on accept.
  task automatic wr(input logic [1:0] addr, input logic [7:0] data);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = addr;
    cfg_if.cfg_data  = data;
    cyc();
    cfg_if.cfg_valid = 1'b0;
    chk("wr_ready_lo", {31'd0, cfg_if.cfg_ready}, 32'd0);
    cyc();
    chk("wr_ready_hi", {31'd0, cfg_if.cfg_ready}, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a"}, {24'd0, ang_a}, 32'd0);
    chk({tag, "_b"}, {24'd0, ang_b}, 32'd0);
    chk({tag, "_frm"}, {16'd0, frm}, 32'd0);
    chk({tag, "_tick"}, {31'd0, tick}, 32'd0);
    chk({tag, "_st"}, {30'd0, st}, 32'd0);
    chk({tag, "_ready"}, {31'd0, cfg_if.cfg_ready}, 32'd1);
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_addr  = 2'd0;
    cfg_if.cfg_data  = 8'd0;

    // Reset with a write request present: it must not be accepted.
    cyc();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 8'h77;
    cyc();
    cfg_if.cfg_valid = 1'b0;
    chk_reset("rst");
    rst_n = 1'b1;
    cyc();
    cyc();

    // Defaults: first FE STOP->RUN without advance, then +2/+1 per frame.
    fe(); chk_frame("def1", 8'd0, 8'd0, 16'd1, 2'd1);
    fe(); chk_frame("def2", 8'd2, 8'd1, 16'd2, 2'd1);
    fe(); chk_frame("def3", 8'd4, 8'd2, 16'd3, 2'd1);
    fe(); chk_frame("def4", 8'd6, 8'd3, 16'd4, 2'd1);

    // Speed A = 0x40, A wraps past 0xFF.
    cyc();
    wr(2'd0, 8'h40);
    cyc();
    chk("spd_no_midframe", {24'd0, ang_a}, 32'd6);
    fe(); chk_frame("spd1", 8'h46, 8'd4, 16'd5, 2'd1);
    fe(); chk_frame("spd2", 8'h86, 8'd5, 16'd6, 2'd1);
    fe(); chk_frame("spd3", 8'hC6, 8'd6, 16'd7, 2'd1);
    fe(); chk_frame("spd4", 8'h06, 8'd7, 16'd8, 2'd1);
    fe(); chk_frame("spd5", 8'h46, 8'd8, 16'd9, 2'd1);

    // Stop (last advance at the FE that leaves RUN), then single step.
    wr(2'd2, 8'h00);
    fe(); chk_frame("stop1", 8'h86, 8'd9, 16'd10, 2'd0);
    fe(); chk_frame("stop2", 8'h86, 8'd9, 16'd11, 2'd0);
    wr(2'd2, 8'h02);
    fe(); chk_frame("step1", 8'h86, 8'd9, 16'd12, 2'd2);
    fe(); chk_frame("step2", 8'hC6, 8'd10, 16'd13, 2'd0);
    fe(); chk_frame("step3", 8'hC6, 8'd10, 16'd14, 2'd0);

    // Run again, then zero the angles; next frame resumes at 2/1.
    wr(2'd2, 8'h01);
    fe(); chk_frame("run", 8'hC6, 8'd10, 16'd15, 2'd1);
    wr(2'd0, 8'h02);
    wr(2'd3, 8'hFF);
    fe(); chk_frame("zero1", 8'd0, 8'd0, 16'd16, 2'd1);
    fe(); chk_frame("zero2", 8'd2, 8'd1, 16'd17, 2'd1);

    // Back-to-back writes with valid held across an FE cycle.
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = 2'd0;
    cfg_if.cfg_data  = 8'h10;
    cyc();                                   // accept A=0x10
    chk("b2b_ready0", {31'd0, cfg_if.cfg_ready}, 32'd0);
    cfg_if.cfg_addr = 2'd1;
    cfg_if.cfg_data = 8'h20;
    vh = 2'b10;
    cyc();                                   // FE: buffer holds, old speeds
    vh = 2'b00;
    chk("b2b_ready_fe", {31'd0, cfg_if.cfg_ready}, 32'd0);
    chk("b2b_fe_a", {24'd0, ang_a}, 32'd4);
    chk("b2b_fe_b", {24'd0, ang_b}, 32'd2);
    chk("b2b_fe_frm", {16'd0, frm}, 32'd18);
    cyc();                                   // drain A
    chk("b2b_ready1", {31'd0, cfg_if.cfg_ready}, 32'd1);
    cyc();                                   // accept B=0x20
    chk("b2b_ready2", {31'd0, cfg_if.cfg_ready}, 32'd0);
    cfg_if.cfg_valid = 1'b0;
    cyc();                                   // drain B
    chk("b2b_ready3", {31'd0, cfg_if.cfg_ready}, 32'd1);
    fe(); chk_frame("b2b_next", 8'h14, 8'h22, 16'd19, 2'd1);

    // cen=0: neither a write nor a vblank edge is taken.
    cen = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = 2'd0;
    cfg_if.cfg_data  = 8'h55;
    vh = 2'b10;
    cyc();
    chk("cen0_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
    chk("cen0_tick", {31'd0, tick}, 32'd0);
    chk("cen0_frm", {16'd0, frm}, 32'd19);
    // cen=1: FE and accept together; FE uses old speeds.
    cen = 1'b1;
    cyc();
    cfg_if.cfg_valid = 1'b0;
    vh = 2'b00;
    chk("sim_tick", {31'd0, tick}, 32'd1);
    chk("sim_a", {24'd0, ang_a}, 32'h24);
    chk("sim_b", {24'd0, ang_b}, 32'h42);
    chk("sim_frm", {16'd0, frm}, 32'd20);
    chk("sim_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    cen = 1'b0;
    cyc();
    chk("hold_tick", {31'd0, tick}, 32'd1);
    chk("hold_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    chk("hold_a", {24'd0, ang_a}, 32'h24);

    // Reset with the 0x55 write still buffered and cen low.
    rst_n = 1'b0;
    cyc();
    chk_reset("rst2");
    // Release with vblank already high: no frame event.
    vh = 2'b10;
    rst_n = 1'b1;
    cen = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("rel_tick", {31'd0, tick}, 32'd0);
    chk("rel_frm", {16'd0, frm}, 32'd0);
    vh = 2'b00;
    cyc();
    // Default speeds prove the buffered write was dropped.
    fe(); chk_frame("post1", 8'd0, 8'd0, 16'd1, 2'd1);
    fe(); chk_frame("post2", 8'd2, 8'd1, 16'd2, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
